// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding the register-file write port: merges a never-stalling
// ALU stream and a ready/valid load stream into one in-order write per cycle.
module regfile_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              A_VALID,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_DATA,
  input  logic [MASK_W-1:0] A_MASK,
  input  logic              L_VALID,
  output logic              L_READY,
  input  logic [ADDR_W-1:0] L_ADDR,
  input  logic [DATA_W-1:0] L_DATA,
  input  logic [MASK_W-1:0] L_MASK,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [DATA_W-1:0] W_DATA,
  output logic [MASK_W-1:0] W_MASK,
  input  logic [ADDR_W-1:0] R_ADDR1,
  input  logic [ADDR_W-1:0] R_ADDR2,
  output logic              HAZ1,
  output logic              HAZ2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } wb_ent_t;

  wb_ent_t          mem [DEPTH];
  wb_ent_t          head_ent;
  logic [PTR_W-1:0] head, tail, tail_l;
  logic [CNT_W-1:0] count;
  logic             pop, full, push_a, push_l;
  logic [DEPTH-1:0] hit1, hit2;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop    = (count != '0);
  assign full   = (count == CNT_W'(DEPTH));
  // With the pop credit, free >= 2 holds exactly when the queue is not full.
  assign L_READY = RST && (!full || !A_VALID);
  assign push_a  = A_VALID;
  assign push_l  = L_VALID && L_READY;
  // The ALU entry takes the tail slot first so it drains ahead of a same-cycle load.
  assign tail_l  = push_a ? wrap_inc(tail) : tail;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= pop ? wrap_inc(head) : head;
      tail  <= push_l ? wrap_inc(tail_l) : tail_l;
      count <= count + CNT_W'(push_a) + CNT_W'(push_l) - CNT_W'(pop);
    end
  end

  // Payload storage carries no reset; validity comes solely from head/count.
  always_ff @(posedge CLK) begin
    if (push_a) mem[tail]   <= '{addr: A_ADDR, data: A_DATA, mask: A_MASK};
    if (push_l) mem[tail_l] <= '{addr: L_ADDR, data: L_DATA, mask: L_MASK};
  end

  assign head_ent = pop ? mem[head] : '0;
  assign RegWrite = pop;
  assign W_ADDR   = head_ent.addr;
  assign W_DATA   = head_ent.data;
  assign W_MASK   = head_ent.mask;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic vld;
    always_comb begin
      int off;
      off = i - int'(head);
      if (off < 0) off = off + DEPTH;
      vld = (off < int'(count));
    end
    assign hit1[i] = vld && (mem[i].addr == R_ADDR1);
    assign hit2[i] = vld && (mem[i].addr == R_ADDR2);
  end

  assign HAZ1 = |hit1;
  assign HAZ2 = |hit2;

endmodule
